// File: rtl/matriz_det_host.sv
// Host-side controller for the 5x5 determinant core: packs a byte stream into the
// matrix bus, holds start until done (or timeout), then streams det out LSB first.
module matriz_det_host #(
  parameter int N       = 5,
  parameter int ELEM_W  = 8,
  parameter int DET_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ELEM_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [7:0]                out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N*N*ELEM_W-1:0]     matriz_A,
  output logic                      start,
  input  logic                      done,
  input  logic [DET_W-1:0]          det,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int NELEM  = N * N;
  localparam int NBYTES = DET_W / 8;
  localparam int EW     = $clog2(NELEM);
  localparam int BW     = $clog2(NBYTES);
  localparam int TW     = $clog2(TIMEOUT);

  typedef enum logic [1:0] {LOAD, RUN, SEND} state_t;

  state_t           state;
  logic [EW-1:0]    elem_cnt;
  logic [BW-1:0]    byte_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic [DET_W-1:0] result;

  // Every output is a register updated together with the state transition that
  // implies it, so the core and the byte link never see decode glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      elem_cnt    <= '0;
      byte_cnt    <= '0;
      tmo_cnt     <= '0;
      result      <= '0;
      matriz_A    <= '0;
      start       <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only; every read below sees the pre-edge value.
      case (state)
        LOAD: begin
          if (in_valid) begin
            matriz_A[elem_cnt*ELEM_W +: ELEM_W] <= in_data;
            if (elem_cnt == '0) timeout_err <= 1'b0;
            if (elem_cnt == EW'(NELEM - 1)) begin
              elem_cnt <= '0;
              state    <= RUN;
              start    <= 1'b1;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              elem_cnt <= elem_cnt + 1'b1;
            end
          end
        end

        RUN: begin
          if (done) begin
            result    <= det;
            out_data  <= det[7:0];
            out_valid <= 1'b1;
            start     <= 1'b0;
            tmo_cnt   <= '0;
            state     <= SEND;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            // Abort: dropping start also clears the core's internal count.
            start       <= 1'b0;
            timeout_err <= 1'b1;
            tmo_cnt     <= '0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            state       <= LOAD;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        SEND: begin
          if (out_ready) begin
            if (byte_cnt == BW'(NBYTES - 1)) begin
              byte_cnt  <= '0;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              state     <= LOAD;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              out_data <= result[(int'(byte_cnt) + 1) * 8 +: 8];
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule
